// File: rtl/mux_arbitrado_if.sv
// Channel/output bundle for mux_arbitrado. i_Last (per-channel last-beat flag) is only
// present when MUX_ARBITRADO_LOCK_EN is defined.
interface mux_arbitrado_if #(
    parameter int BUS_SIZE  = 32,
    parameter int N_INPUTS  = 4,
    parameter int SEL_WIDTH = $clog2(N_INPUTS)
);
    logic                         i_Modo;
    logic [SEL_WIDTH-1:0]         i_Control;
    logic [N_INPUTS-1:0]          i_Valid;
    logic [N_INPUTS*BUS_SIZE-1:0] i_Data;
`ifdef MUX_ARBITRADO_LOCK_EN
    logic [N_INPUTS-1:0]          i_Last;
`endif
    logic                         i_Ready;
    logic [N_INPUTS-1:0]          o_Ready;
    logic                         o_Valid;
    logic [BUS_SIZE-1:0]          o_Salida;
    logic [SEL_WIDTH-1:0]         o_Grant;

`ifdef MUX_ARBITRADO_LOCK_EN
    modport master (
        output i_Modo, i_Control, i_Valid, i_Data, i_Last, i_Ready,
        input  o_Ready, o_Valid, o_Salida, o_Grant
    );
    modport slave (
        input  i_Modo, i_Control, i_Valid, i_Data, i_Last, i_Ready,
        output o_Ready, o_Valid, o_Salida, o_Grant
    );
`else
    modport master (
        output i_Modo, i_Control, i_Valid, i_Data, i_Ready,
        input  o_Ready, o_Valid, o_Salida, o_Grant
    );
    modport slave (
        input  i_Modo, i_Control, i_Valid, i_Data, i_Ready,
        output o_Ready, o_Valid, o_Salida, o_Grant
    );
`endif
endinterface

// File: rtl/mux_arbitrado.sv
// N-input mux with fixed-select or round-robin arbitration into a single registered slot.
// Define MUX_ARBITRADO_LOCK_EN to hold the grant on one channel until its i_Last beat.
module mux_arbitrado #(
    parameter int BUS_SIZE  = 32,
    parameter int N_INPUTS  = 4,
    parameter int SEL_WIDTH = $clog2(N_INPUTS)
) (
    input logic            i_Clock,
    input logic            i_Reset,
    mux_arbitrado_if.slave bus
);

    logic                 valid_q;
    logic [BUS_SIZE-1:0]  salida_q;
    logic [SEL_WIDTH-1:0] grant_q;
    logic [SEL_WIDTH-1:0] rr_ptr_q;
    logic [SEL_WIDTH-1:0] rr_ptr_d;

    logic                 acepta;
    logic                 has_win;
    logic                 transfer;
    logic                 ptr_adv;
    logic [SEL_WIDTH-1:0] win_idx;
    logic [BUS_SIZE-1:0]  win_data;

`ifdef MUX_ARBITRADO_LOCK_EN
    localparam logic [0:0] UNLOCKED = 1'b0;
    localparam logic [0:0] LOCKED   = 1'b1;

    logic [0:0]           state_q;
    logic [SEL_WIDTH-1:0] lock_idx_q;
`endif

    assign acepta = !valid_q || bus.i_Ready;

    always_comb begin : arbiter
        int                   idx;
        logic [SEL_WIDTH-1:0] cand;
        has_win = 1'b0;
        win_idx = '0;
        idx     = 0;
        cand    = '0;
`ifdef MUX_ARBITRADO_LOCK_EN
        if (state_q == LOCKED) begin
            has_win = bus.i_Valid[lock_idx_q];
            win_idx = lock_idx_q;
        end else
`endif
        if (!bus.i_Modo) begin
            if (int'(bus.i_Control) < N_INPUTS && bus.i_Valid[bus.i_Control]) begin
                has_win = 1'b1;
                win_idx = bus.i_Control;
            end
        end else begin
            // Scan offsets high to low so the hit closest to rr_ptr is the last one kept.
            for (int i = N_INPUTS - 1; i >= 0; i--) begin
                idx = int'(rr_ptr_q) + i;
                if (idx >= N_INPUTS) idx = idx - N_INPUTS;
                cand = SEL_WIDTH'(idx);
                if (bus.i_Valid[cand]) begin
                    has_win = 1'b1;
                    win_idx = cand;
                end
            end
        end
    end

    always_comb begin
        win_data    = '0;
        bus.o_Ready = '0;
        for (int k = 0; k < N_INPUTS; k++) begin
            if (win_idx == SEL_WIDTH'(k)) begin
                win_data       = bus.i_Data[k*BUS_SIZE +: BUS_SIZE];
                bus.o_Ready[k] = acepta && has_win && !i_Reset;
            end
        end
    end

    assign transfer = acepta && has_win;
    assign rr_ptr_d = (win_idx == SEL_WIDTH'(N_INPUTS - 1)) ? '0 : win_idx + SEL_WIDTH'(1);

`ifdef MUX_ARBITRADO_LOCK_EN
    // Pointer moves only when a packet completes, so a locked packet never skews fairness.
    assign ptr_adv = transfer && bus.i_Last[win_idx];

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q    <= UNLOCKED;
            lock_idx_q <= '0;
        end else if (transfer) begin
            if (bus.i_Last[win_idx]) begin
                state_q <= UNLOCKED;
            end else begin
                state_q    <= LOCKED;
                lock_idx_q <= win_idx;
            end
        end
    end
`else
    assign ptr_adv = transfer;
`endif

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            valid_q  <= 1'b0;
            salida_q <= '0;
            grant_q  <= '0;
        end else if (acepta) begin
            valid_q <= has_win;
            if (has_win) begin
                salida_q <= win_data;
                grant_q  <= win_idx;
            end
        end
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            rr_ptr_q <= '0;
        end else if (ptr_adv) begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign bus.o_Valid  = valid_q;
    assign bus.o_Salida = salida_q;
    assign bus.o_Grant  = grant_q;

endmodule
